// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
// Optional per-channel transfer counters are enabled with STREAM_DEMUX_CNT_EN.
package stream_demux_pkg;
    localparam int N_OUT = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/stream_demux_slot.sv
// Single-entry register slice for one demux output channel.
// A load in the same cycle as a drain takes priority, so the slot stays full.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_drain,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1:4 valid/ready demux with one slot per output channel.
// Define STREAM_DEMUX_CNT_EN to add saturating per-channel transfer counters (dn_cnt).
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [W-1:0]           up_data,
    input  logic [1:0]             up_sel,
    output logic [3:0]             dn_valid,
    input  logic [3:0]             dn_ready,
    output logic [4*W-1:0]         dn_data
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [N_OUT*CNT_W-1:0] dn_cnt
`endif
);
    sel_t                      w_sel;
    logic [N_OUT-1:0]          w_dec;
    logic [N_OUT-1:0]          w_free;
    logic [N_OUT-1:0]          w_drain;
    logic [N_OUT-1:0]          w_load;
    logic [N_OUT-1:0][W-1:0]   w_data;

    assign w_sel = up_sel;

    // One-hot channel decode in plain gates; up_valid stays out of the ready path.
    assign w_dec[0] = ~w_sel[1] & ~w_sel[0];
    assign w_dec[1] = ~w_sel[1] &  w_sel[0];
    assign w_dec[2] =  w_sel[1] & ~w_sel[0];
    assign w_dec[3] =  w_sel[1] &  w_sel[0];

    assign w_free   = ~dn_valid | dn_ready;
    assign w_drain  =  dn_valid & dn_ready;
    assign up_ready = |(w_dec & w_free);
    assign w_load   = w_dec & {N_OUT{up_valid & up_ready}};

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        stream_demux_slot #(.W(W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_drain (w_drain[g]),
            .i_data  (up_data),
            .o_valid (dn_valid[g]),
            .o_data  (w_data[g])
        );
    end

    assign dn_data = w_data;

`ifdef STREAM_DEMUX_CNT_EN
    logic [N_OUT-1:0][CNT_W-1:0] r_cnt;

    for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_cnt[g] <= '0;
            else if (w_drain[g] && (r_cnt[g] != {CNT_W{1'b1}}))
                r_cnt[g] <= r_cnt[g] + CNT_W'(1);
        end
    end

    assign dn_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed vector table, hand-written corner sequences,
// and a randomized phase checked against per-channel FIFO queues.
module tb_stream_demux_1_4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         up_valid = 1'b0;
    logic         up_ready;
    logic [W-1:0] up_data = '0;
    logic [1:0]   up_sel = '0;
    logic [3:0]   dn_valid;
    logic [3:0]   dn_ready = '0;
    logic [4*W-1:0] dn_data;
`ifdef STREAM_DEMUX_CNT_EN
    logic [31:0]  dn_cnt;
`endif

    always #5 clk = ~clk;

    stream_demux_1_4 #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .up_data  (up_data),
        .up_sel   (up_sel),
        .dn_valid (dn_valid),
        .dn_ready (dn_ready),
        .dn_data  (dn_data)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .dn_cnt   (dn_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
        up_valid = v;
        up_sel   = s;
        up_data  = d;
        dn_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 4'h0, 4'h0);
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [3:0] d;
        logic [3:0] rdy;
        logic       ur;
        logic [3:0] dv;
        logic [15:0] dd;
    } vec_t;

    vec_t tbl[19];

    // Reference model: one FIFO per channel holding beats accepted but not yet delivered.
    logic [3:0] q[4][$];
    int         mcnt[4];

    initial begin
        tbl = '{
            '{1'b1, 2'd2, 4'hA, 4'hF, 1'b1, 4'b0000, 16'h0000},
            '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0100, 16'h0A00},
            '{1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'b0000, 16'h0A00},
            '{1'b1, 2'd1, 4'h3, 4'h0, 1'b1, 4'b0000, 16'h0A00},
            '{1'b1, 2'd1, 4'h5, 4'h0, 1'b0, 4'b0010, 16'h0A30},
            '{1'b1, 2'd1, 4'h5, 4'h0, 1'b0, 4'b0010, 16'h0A30},
            '{1'b1, 2'd1, 4'h5, 4'h2, 1'b1, 4'b0010, 16'h0A30},
            '{1'b0, 2'd1, 4'h0, 4'h2, 1'b1, 4'b0010, 16'h0A50},
            '{1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'b0000, 16'h0A50},
            '{1'b1, 2'd0, 4'h9, 4'h0, 1'b1, 4'b0000, 16'h0A50},
            '{1'b1, 2'd3, 4'h7, 4'h0, 1'b1, 4'b0001, 16'h0A59},
            '{1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 4'b1001, 16'h7A59},
            '{1'b1, 2'd0, 4'h1, 4'h0, 1'b0, 4'b1001, 16'h7A59},
            '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b1001, 16'h7A59},
            '{1'b1, 2'd2, 4'hC, 4'hF, 1'b1, 4'b0000, 16'h7A59},
            '{1'b1, 2'd2, 4'hD, 4'hF, 1'b1, 4'b0100, 16'h7C59},
            '{1'b0, 2'd2, 4'h0, 4'hF, 1'b1, 4'b0100, 16'h7D59},
            '{1'b0, 2'd1, 4'h6, 4'h0, 1'b1, 4'b0000, 16'h7D59},
            '{1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'b0000, 16'h7D59}
        };

        // Reset state, sampled while reset is still asserted.
        #1 rst_n = 1'b0;
        tick();
        chk("rst_dn_valid", 32'(dn_valid), 32'h0);
        chk("rst_dn_data",  32'(dn_data),  32'h0);
        chk("rst_up_ready", 32'(up_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed vector table.
        for (int k = 0; k < 19; k++) begin
            drive(tbl[k].v, tbl[k].sel, tbl[k].d, tbl[k].rdy);
            #1;
            chk($sformatf("tbl%0d_up_ready", k), 32'(up_ready), 32'(tbl[k].ur));
            chk($sformatf("tbl%0d_dn_valid", k), 32'(dn_valid), 32'(tbl[k].dv));
            chk($sformatf("tbl%0d_dn_data",  k), 32'(dn_data),  32'(tbl[k].dd));
            tick();
        end

        // Back-to-back streaming to one channel: 16 beats in 16 cycles.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 2'd2, 4'(k), 4'hF);
            #1;
            chk($sformatf("stream%0d_up_ready", k), 32'(up_ready), 32'h1);
            if (k > 0) begin
                chk($sformatf("stream%0d_valid", k), 32'(dn_valid), 32'h4);
                chk($sformatf("stream%0d_data", k), 32'(dn_data[11:8]), 32'(k - 1));
            end
            tick();
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        #1;
        chk("stream_last_valid", 32'(dn_valid), 32'h4);
        chk("stream_last_data",  32'(dn_data[11:8]), 32'hF);
        tick();
        chk("stream_empty", 32'(dn_valid), 32'h0);

        // Fill every slot, then assert reset asynchronously between edges.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 4'(i + 1), 4'h0);
            tick();
        end
        drive(1'b0, 2'd0, 4'h0, 4'h0);
        #1;
        chk("full_valid", 32'(dn_valid), 32'hF);
        chk("full_data",  32'(dn_data),  32'h4321);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(dn_valid), 32'h0);
        chk("async_rst_data",  32'(dn_data),  32'h0);
        chk("async_rst_ready", 32'(up_ready), 32'h1);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(dn_valid), 32'h0);

        // Randomized phase against the queue model.
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            mcnt[i] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            logic       exp_ur;
            logic       fire;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
            #1;
            exp_ur = (q[up_sel].size() == 0) || dn_ready[up_sel];
            chk("rnd_up_ready", 32'(up_ready), 32'(exp_ur));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rnd_valid%0d", i), 32'(dn_valid[i]), 32'(q[i].size() != 0));
                if (q[i].size() != 0)
                    chk($sformatf("rnd_data%0d", i), 32'(dn_data[i*W +: W]), 32'(q[i][0]));
`ifdef STREAM_DEMUX_CNT_EN
                chk($sformatf("rnd_cnt%0d", i), 32'(dn_cnt[i*8 +: 8]), 32'(mcnt[i]));
`endif
            end
            fire = up_valid && exp_ur;
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() != 0 && dn_ready[i]) begin
                    void'(q[i].pop_front());
                    if (mcnt[i] < 255) mcnt[i]++;
                end
            end
            if (fire) q[up_sel].push_back(up_data);
            tick();
        end

`ifdef STREAM_DEMUX_CNT_EN
        // Counter saturation: 300 transfers on channel 1.
        do_reset();
        tick();
        for (int c = 0; c < 300; c++) begin
            drive(1'b1, 2'd1, 4'(c), 4'hF);
            tick();
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        tick();
        chk("cnt_saturate", dn_cnt, 32'h0000FF00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
